// File: rtl/adc_input_common.sv
// Shared register map and bit masks for the adc_input register block.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Used by both the read and write halves of the AXI-Lite register window so
// the address map and field masks live in exactly one place.
package adc_input_common;

    // Register byte offsets within the AXI-Lite window.
    localparam logic [31:0] AXI_ADDR_CR    = 32'h0000_0000;
    localparam logic [31:0] AXI_ADDR_SR    = 32'h0000_0004;
    localparam logic [31:0] AXI_ADDR_DSIZE = 32'h0000_0008;

    // Field masks.
    localparam logic [31:0] _CR_TEST = 32'h0000_0001;
    localparam logic [31:0] _SR_PC   = 32'h0000_0001;

endpackage

// File: rtl/adc_input_axi_write.sv
// AXI-Lite write slave for the adc_input register window (CR, SR, DSIZE).
// Latency: final AW/W handshake -> register update 1 cycle later -> BVALID 2 cycles later.
// Backpressure: single outstanding write; AW/W stall until the B response is taken by BREADY.
//
// Ports:
//   ACLK, ARESETN           clock, asynchronous active-low reset
//   AWADDR/AWVALID/AWREADY  write-address channel
//   WDATA/WSTRB/WVALID/WREADY write-data channel
//   BRESP/BVALID/BREADY     write-response channel (always OKAY)
//   dsize                   DSIZE register value
//   cr_test                 CR test bit
//   sr_pc_clr               one-cycle pulse asking the owner of SR to clear its PC flag
module adc_input_axi_write
    import adc_input_common::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'd0,
    parameter logic [31:0] C_HIGHADDR = 32'd0
) (
    input  logic        ACLK,
    input  logic        ARESETN,

    input  logic [31:0] AWADDR,
    input  logic        AWVALID,
    output logic        AWREADY,

    input  logic [31:0] WDATA,
    input  logic [3:0]  WSTRB,
    input  logic        WVALID,
    output logic        WREADY,

    output logic [1:0]  BRESP,
    output logic        BVALID,
    input  logic        BREADY,

    output logic [31:0] dsize,
    output logic        cr_test,
    output logic        sr_pc_clr
);

    typedef enum logic [2:0] {
        IDLE,
        HAVE_A,
        HAVE_W,
        WRITE,
        RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // The upper bound is informational; a non-zero bound that cannot hold
    // the whole register map is a configuration mistake worth stopping on.
    if (C_HIGHADDR != 32'd0 && C_HIGHADDR < C_BASEADDR + AXI_ADDR_DSIZE + 32'd3) begin : g_window_check
        $error("adc_input_axi_write: C_HIGHADDR does not cover the register map");
    end

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic        aw_hs;
    logic        w_hs;
    logic        hit_cr;
    logic        hit_sr;
    logic        hit_dsize;

    // Ready signals depend on state only, so a master may present AW and W
    // in any order or together without a combinational path through us.
    assign AWREADY = (state == IDLE) || (state == HAVE_W);
    assign WREADY  = (state == IDLE) || (state == HAVE_A);
    assign BRESP   = RESP_OKAY;

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;

    // Exact full-width match; anything else in the window is silently ignored.
    assign hit_cr    = (addr_q == C_BASEADDR + AXI_ADDR_CR);
    assign hit_sr    = (addr_q == C_BASEADDR + AXI_ADDR_SR);
    assign hit_dsize = (addr_q == C_BASEADDR + AXI_ADDR_DSIZE);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            BVALID    <= 1'b0;
            dsize     <= '0;
            cr_test   <= 1'b0;
            sr_pc_clr <= 1'b0;
        end else begin
            // sr_pc_clr is a pulse: it only survives the cycle it is set in.
            sr_pc_clr <= 1'b0;

            if (aw_hs) begin
                addr_q <= AWADDR;
            end
            if (w_hs) begin
                wdata_q <= WDATA;
                wstrb_q <= WSTRB;
            end

            case (state)
                IDLE: begin
                    if (aw_hs && w_hs) begin
                        state <= WRITE;
                    end else if (aw_hs) begin
                        state <= HAVE_A;
                    end else if (w_hs) begin
                        state <= HAVE_W;
                    end
                end

                HAVE_A: begin
                    if (w_hs) begin
                        state <= WRITE;
                    end
                end

                HAVE_W: begin
                    if (aw_hs) begin
                        state <= WRITE;
                    end
                end

                WRITE: begin
                    if (hit_dsize) begin
                        for (int i = 0; i < 4; i++) begin
                            if (wstrb_q[i]) begin
                                dsize[i*8 +: 8] <= wdata_q[i*8 +: 8];
                            end
                        end
                    end
                    if (hit_cr && wstrb_q[0]) begin
                        cr_test <= |(wdata_q & _CR_TEST);
                    end
                    if (hit_sr && wstrb_q[0] && |(wdata_q & _SR_PC)) begin
                        sr_pc_clr <= 1'b1;
                    end
                    state <= RESP;
                end

                RESP: begin
                    // First RESP cycle raises BVALID, so the written value is
                    // visible one cycle before the response; then hold for BREADY.
                    if (!BVALID) begin
                        BVALID <= 1'b1;
                    end else if (BREADY) begin
                        BVALID <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_input_axi_write.sv
// Self-checking bench for adc_input_axi_write.
// Latency: n/a (testbench).
// Backpressure: drives BREADY low for chosen stretches to hold the response.
module tb_adc_input_axi_write;

    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [31:0] dsize;
    logic        cr_test;
    logic        sr_pc_clr;

    adc_input_axi_write #(
        .C_BASEADDR (BASE),
        .C_HIGHADDR (BASE + 32'h0000_00FF)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .AWADDR    (AWADDR),
        .AWVALID   (AWVALID),
        .AWREADY   (AWREADY),
        .WDATA     (WDATA),
        .WSTRB     (WSTRB),
        .WVALID    (WVALID),
        .WREADY    (WREADY),
        .BRESP     (BRESP),
        .BVALID    (BVALID),
        .BREADY    (BREADY),
        .dsize     (dsize),
        .cr_test   (cr_test),
        .sr_pc_clr (sr_pc_clr)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    // Expected observable state of the register block.
    logic [31:0] m_dsize  = '0;
    logic        m_cr     = 1'b0;
    logic        m_pc     = 1'b0;
    logic        m_bvalid = 1'b0;
    logic        cmp_en   = 1'b0;
    int          pc_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Register-map semantics: what a write does to the visible outputs.
    task automatic model_apply(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        if (a == BASE + 32'h8) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) m_dsize[i*8 +: 8] = d[i*8 +: 8];
            end
        end
        if (a == BASE && s[0]) m_cr = d[0];
        if (a == BASE + 32'h4 && s[0] && d[0]) m_pc = 1'b1;
    endtask

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge ACLK) begin
        if (cmp_en) begin
            chk("cyc_dsize", dsize, m_dsize);
            chk("cyc_cr_test", 32'(cr_test), 32'(m_cr));
            chk("cyc_sr_pc_clr", 32'(sr_pc_clr), 32'(m_pc));
            chk("cyc_bvalid", 32'(BVALID), 32'(m_bvalid));
            chk("cyc_bresp", 32'(BRESP), 32'd0);
            if (sr_pc_clr) pc_cycles++;
        end
    end

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hit, w_hit;
        int cyc = 0;
        while (!(aw_done && w_done) && cyc < 64) begin
            AWADDR  = a;
            WDATA   = d;
            WSTRB   = s;
            AWVALID = !aw_done && (cyc >= aw_dly);
            WVALID  = !w_done && (cyc >= w_dly);
            if (!aw_done && !w_done) begin
                chk("rdy_idle_aw", 32'(AWREADY), 32'd1);
                chk("rdy_idle_w", 32'(WREADY), 32'd1);
            end else if (w_done) begin
                chk("rdy_have_w_aw", 32'(AWREADY), 32'd1);
                chk("rdy_have_w_w", 32'(WREADY), 32'd0);
            end else begin
                chk("rdy_have_a_aw", 32'(AWREADY), 32'd0);
                chk("rdy_have_a_w", 32'(WREADY), 32'd1);
            end
            aw_hit = AWVALID && AWREADY;
            w_hit  = WVALID && WREADY;
            @(posedge ACLK); #1;
            aw_done |= aw_hit;
            w_done  |= w_hit;
            cyc++;
        end
        AWVALID = 1'b0;
        WVALID  = 1'b0;
        if (!(aw_done && w_done)) begin
            chk("handshake_timeout", 32'd0, 32'd1);
        end else begin
            chk("rdy_write_aw", 32'(AWREADY), 32'd0);
            chk("rdy_write_w", 32'(WREADY), 32'd0);
            @(posedge ACLK); #1;
            model_apply(a, d, s);
            @(posedge ACLK); #1;
            m_pc     = 1'b0;
            m_bvalid = 1'b1;
            BREADY   = (b_dly == 0);
            for (int i = 0; i < b_dly; i++) begin
                chk("rdy_resp_aw", 32'(AWREADY), 32'd0);
                chk("rdy_resp_w", 32'(WREADY), 32'd0);
                @(posedge ACLK); #1;
            end
            BREADY = 1'b1;
            chk("rdy_resp_aw", 32'(AWREADY), 32'd0);
            chk("rdy_resp_w", 32'(WREADY), 32'd0);
            @(posedge ACLK); #1;
            m_bvalid = 1'b0;
            BREADY   = 1'b0;
            chk("rdy_back_idle", {30'd0, AWREADY, WREADY}, 32'd3);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (2) @(posedge ACLK);
        #1;
        chk("rst_awready", 32'(AWREADY), 32'd1);
        chk("rst_wready", 32'(WREADY), 32'd1);
        chk("rst_bvalid", 32'(BVALID), 32'd0);
        chk("rst_bresp", 32'(BRESP), 32'd0);
        chk("rst_dsize", dsize, 32'd0);
        chk("rst_cr_test", 32'(cr_test), 32'd0);
        chk("rst_sr_pc_clr", 32'(sr_pc_clr), 32'd0);
        ARESETN = 1'b1;
        cmp_en  = 1'b1;
        @(posedge ACLK); #1;

        // AW and W together, DSIZE full word.
        axi_write(BASE + 32'h8, 32'h0000_1000, 4'hF, 0, 0, 0);
        chk("lit_dsize_1000", dsize, 32'h0000_1000);

        // Clear DSIZE, then W first with byte strobes and AW three cycles later.
        axi_write(BASE + 32'h8, 32'h0, 4'hF, 0, 0, 0);
        axi_write(BASE + 32'h8, 32'hAABB_CCDD, 4'b0101, 3, 0, 0);
        chk("lit_dsize_strb", dsize, 32'h00BB_00DD);

        // AW first, then W two cycles later; upper bytes only.
        axi_write(BASE + 32'h8, 32'h1122_3344, 4'b1000, 0, 2, 0);
        chk("lit_dsize_aw_first", dsize, 32'h11BB_00DD);

        // CR test bit.
        axi_write(BASE, 32'h1, 4'h1, 0, 0, 0);
        chk("lit_cr_set", 32'(cr_test), 32'd1);
        axi_write(BASE, 32'h0, 4'h1, 0, 0, 0);
        chk("lit_cr_clr", 32'(cr_test), 32'd0);
        axi_write(BASE, 32'h1, 4'h1, 0, 0, 0);
        axi_write(BASE, 32'h0, 4'hE, 0, 0, 0);
        chk("lit_cr_nostrb", 32'(cr_test), 32'd1);

        // SR PC clear pulse.
        pc_cycles = 0;
        axi_write(BASE + 32'h4, 32'h1, 4'h1, 1, 0, 0);
        chk("lit_pc_pulse_len", pc_cycles, 32'd1);
        pc_cycles = 0;
        axi_write(BASE + 32'h4, 32'h0, 4'hF, 0, 0, 0);
        axi_write(BASE + 32'h4, 32'h1, 4'h0, 0, 0, 0);
        chk("lit_pc_no_pulse", pc_cycles, 32'd0);

        // Response held by BREADY low for five cycles.
        axi_write(BASE + 32'h8, 32'hCAFE_F00D, 4'hF, 0, 0, 5);
        chk("lit_dsize_stall", dsize, 32'hCAFE_F00D);

        // Unmapped addresses: OKAY, nothing changes.
        axi_write(BASE + 32'h40, 32'hFFFF_FFFF, 4'hF, 0, 0, 2);
        axi_write(32'h0000_0008, 32'h1234_5678, 4'hF, 0, 0, 0);
        axi_write(BASE + 32'h9, 32'h1234_5678, 4'hF, 0, 0, 0);
        chk("lit_unmapped_dsize", dsize, 32'hCAFE_F00D);
        chk("lit_unmapped_cr", 32'(cr_test), 32'd1);

        // Reset while only the address has been accepted.
        AWADDR  = BASE + 32'h8;
        AWVALID = 1'b1;
        @(posedge ACLK); #1;
        AWVALID = 1'b0;
        chk("rst_mid_have_a", {30'd0, AWREADY, WREADY}, 32'd1);
        ARESETN  = 1'b0;
        m_dsize  = '0;
        m_cr     = 1'b0;
        m_pc     = 1'b0;
        m_bvalid = 1'b0;
        #1;
        chk("rst_mid_dsize", dsize, 32'd0);
        chk("rst_mid_cr", 32'(cr_test), 32'd0);
        chk("rst_mid_rdy", {30'd0, AWREADY, WREADY}, 32'd3);
        repeat (2) @(posedge ACLK);
        #1;
        ARESETN = 1'b1;
        repeat (6) @(posedge ACLK);
        #1;
        chk("rst_mid_idle", {30'd0, AWREADY, WREADY}, 32'd3);
        axi_write(BASE + 32'h8, 32'h0000_0ABC, 4'hF, 0, 1, 1);
        chk("lit_after_reset", dsize, 32'h0000_0ABC);

        repeat (2) @(posedge ACLK);
        cmp_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
